// File: rtl/shape_sel_ctrl_pkg.sv
// Shared shape codes, selection state encoding and step helper for the shape selector.
package shape_sel_ctrl_pkg;

  localparam int unsigned SHAPE_W = 2;

  localparam logic [SHAPE_W-1:0] SHAPE_SQUARE = 2'b00;
  localparam logic [SHAPE_W-1:0] SHAPE_CIRCLE = 2'b01;
  localparam logic [SHAPE_W-1:0] SHAPE_LINE   = 2'b10;

  // Selection state is encoded directly as the mux select code.
  typedef enum logic [SHAPE_W-1:0] {
    SEL_SQUARE = SHAPE_SQUARE,
    SEL_CIRCLE = SHAPE_CIRCLE,
    SEL_LINE   = SHAPE_LINE,
    SEL_BAD    = 2'b11
  } sel_state_e;

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_NEXT = 2'b01,
    STEP_PREV = 2'b10
  } step_e;

  // Debounced press pulses from both buttons for one cycle.
  typedef struct packed {
    logic next;
    logic prev;
  } btn_press_t;

  // Next selection for a given step; the unused code always recovers to SQUARE.
  function automatic sel_state_e sel_advance(input sel_state_e cur, input step_e step);
    sel_state_e res;
    res = cur;
    case (cur)
      SEL_SQUARE: begin
        if (step == STEP_NEXT)      res = SEL_CIRCLE;
        else if (step == STEP_PREV) res = SEL_LINE;
      end
      SEL_CIRCLE: begin
        if (step == STEP_NEXT)      res = SEL_LINE;
        else if (step == STEP_PREV) res = SEL_SQUARE;
      end
      SEL_LINE: begin
        if (step == STEP_NEXT)      res = SEL_SQUARE;
        else if (step == STEP_PREV) res = SEL_CIRCLE;
      end
      default: res = SEL_SQUARE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/shape_sel_ctrl_btn_debounce.sv
// Raw push-button conditioning: 2-FF synchronizer, stable-level debounce, press edge.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned DB_W      = 19
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [DB_W-1:0] cnt_q,   cnt_d;

  // Debounce counter runs only while the synced level disagrees with the accepted one.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
    // Press is registered in the same edge the accepted level rises.
    press_d = level_d & ~level_q;
  end

  // Conditioning state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/shape_sel_ctrl.sv
// Shape select sequencer: debounced next/prev buttons plus auto-cycle drive the mux code.
module shape_sel_ctrl
  import shape_sel_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 500000,
  parameter int unsigned DB_W        = 19,
  parameter int unsigned AUTO_FRAMES = 120,
  parameter int unsigned AF_W        = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               btn_next,
  input  logic               btn_prev,
  input  logic               auto_en,
  input  logic               frame_tick,
  output logic [SHAPE_W-1:0] selec,
  output logic               sel_changed
);

  localparam logic [AF_W-1:0] AF_LAST = AF_W'(AUTO_FRAMES - 1);

  btn_press_t      press;
  logic            unused_lvl_next;
  logic            unused_lvl_prev;

  sel_state_e      state_q, state_d;
  logic [AF_W-1:0] af_q, af_d;
  logic            sel_changed_q, sel_changed_d;
  step_e           step;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_db_next (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_raw (btn_next),
    .level   (unused_lvl_next),
    .press   (press.next)
  );

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_db_prev (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_raw (btn_prev),
    .level   (unused_lvl_prev),
    .press   (press.prev)
  );

  // Step arbitration: manual presses beat the auto step; simultaneous presses cancel.
  always_comb begin
    step          = STEP_NONE;
    af_d          = af_q;
    state_d       = state_q;
    sel_changed_d = 1'b0;
    if (press.next && press.prev) begin
      af_d = '0;
    end else if (press.next) begin
      step = STEP_NEXT;
      af_d = '0;
    end else if (press.prev) begin
      step = STEP_PREV;
      af_d = '0;
    end else if (!auto_en) begin
      af_d = '0;
    end else if (frame_tick) begin
      if (af_q == AF_LAST) begin
        af_d = '0;
        step = STEP_NEXT;
      end else begin
        af_d = af_q + AF_W'(1);
      end
    end
    state_d       = sel_advance(state_q, step);
    sel_changed_d = (state_d != state_q);
  end

  // Selection state, auto frame counter and change pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SEL_SQUARE;
      af_q          <= '0;
      sel_changed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      af_q          <= af_d;
      sel_changed_q <= sel_changed_d;
    end
  end

  assign selec       = state_q;
  assign sel_changed = sel_changed_q;

endmodule

// File: tb/tb_shape_sel_ctrl.sv
// Scoreboard bench for shape_sel_ctrl with short debounce and auto periods.
module tb_shape_sel_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic       auto_en = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] selec;
  logic       sel_changed;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         pulse_cnt = 0;
  logic [1:0] exp_q[$];
  logic [1:0] prev_sel = 2'b00;

  shape_sel_ctrl #(
    .DB_CYCLES   (4),
    .DB_W        (3),
    .AUTO_FRAMES (3),
    .AF_W        (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_next    (btn_next),
    .btn_prev    (btn_prev),
    .auto_en     (auto_en),
    .frame_tick  (frame_tick),
    .selec       (selec),
    .sel_changed (sel_changed)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_tests++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for all queued expected selections to be observed.
  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic press_btn(input bit is_next);
    if (is_next) btn_next = 1'b1; else btn_prev = 1'b1;
    repeat (10) tick();
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (12) tick();
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Monitor: every change pulse pops an expected code; no silent changes allowed.
  always @(negedge clk) begin
    logic [1:0] e;
    if (!reset_n) begin
      check_eq("rst_selec", int'(selec), 0);
      check_eq("rst_pulse", int'(sel_changed), 0);
      prev_sel = selec;
    end else begin
      if (sel_changed) begin
        pulse_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_pulse", int'(selec), int'(prev_sel));
        end else begin
          e = exp_q.pop_front();
          check_eq("selec", int'(selec), int'(e));
        end
      end else if (selec != prev_sel) begin
        check_eq("silent_change", int'(selec), int'(prev_sel));
      end
      prev_sel = selec;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got 1 expected 0");
    $fatal(1);
  end

  initial begin
    int n;
    int base;

    // Reset state
    do_reset();
    check_eq("init_selec", int'(selec), 0);
    check_eq("init_pulse", int'(sel_changed), 0);

    // Long hold on next: one step, fixed latency
    base = pulse_cnt;
    exp_q.push_back(2'b01);
    btn_next = 1'b1;
    n = 0;
    while (!sel_changed && n < 30) begin
      tick();
      n++;
    end
    check_eq("latency", n, 7);
    repeat (20 - n) tick();
    btn_next = 1'b0;
    repeat (15) tick();
    drain("drain_hold", 5);
    check_eq("hold_pulses", pulse_cnt - base, 1);
    check_eq("hold_selec", int'(selec), 1);

    // Two-cycle glitch is rejected
    do_reset();
    base = pulse_cnt;
    btn_next = 1'b1;
    repeat (2) tick();
    btn_next = 1'b0;
    repeat (20) tick();
    check_eq("glitch_selec", int'(selec), 0);
    check_eq("glitch_pulses", pulse_cnt - base, 0);

    // Three prev presses wrap backwards
    base = pulse_cnt;
    exp_q.push_back(2'b10);
    press_btn(1'b0);
    drain("drain_prev1", 5);
    exp_q.push_back(2'b01);
    press_btn(1'b0);
    drain("drain_prev2", 5);
    exp_q.push_back(2'b00);
    press_btn(1'b0);
    drain("drain_prev3", 5);
    check_eq("prev_pulses", pulse_cnt - base, 3);

    // Simultaneous next+prev cancel
    base = pulse_cnt;
    btn_next = 1'b1;
    btn_prev = 1'b1;
    repeat (12) tick();
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (12) tick();
    check_eq("both_selec", int'(selec), 0);
    check_eq("both_pulses", pulse_cnt - base, 0);

    // Auto mode: step every third frame
    base = pulse_cnt;
    auto_en = 1'b1;
    tick();
    for (int t = 1; t <= 9; t++) begin
      if (t == 3) exp_q.push_back(2'b01);
      if (t == 6) exp_q.push_back(2'b10);
      if (t == 9) exp_q.push_back(2'b00);
      frame();
    end
    drain("drain_auto", 5);
    check_eq("auto_pulses", pulse_cnt - base, 3);
    auto_en = 1'b0;
    tick();

    // Manual press clears the frame counter
    auto_en = 1'b1;
    tick();
    frame();
    frame();
    exp_q.push_back(2'b01);
    press_btn(1'b1);
    drain("drain_manual", 5);
    frame();
    frame();
    check_eq("restart_selec", int'(selec), 1);
    exp_q.push_back(2'b10);
    frame();
    drain("drain_restart", 5);
    auto_en = 1'b0;
    tick();

    // Reset mid-debounce with button held through release
    base = pulse_cnt;
    btn_next = 1'b1;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_selec", int'(selec), 0);
    repeat (2) tick();
    exp_q.push_back(2'b01);
    reset_n = 1'b1;
    drain("drain_after_rst", 20);
    btn_next = 1'b0;
    repeat (12) tick();
    check_eq("rst_hold_pulses", pulse_cnt - base, 1);
    check_eq("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
